// File: rtl/dmem_pkg.sv
// Shared types and helpers for the protected read-modify-write data memory.
package dmem_pkg;

  typedef enum logic {IDLE = 1'b0, RMW = 1'b1} dmem_state_t;

  localparam logic [31:0] DMEM_PROTECT_MASK_DEF = 32'h0000_003F;

  // Widest data word the merge helper supports; callers zero-extend.
  localparam int DMEM_MAX_W = 64;

  function automatic logic [DMEM_MAX_W-1:0] dmem_merge(
    input logic [DMEM_MAX_W-1:0] wdata,
    input logic [DMEM_MAX_W-1:0] old,
    input logic [DMEM_MAX_W-1:0] mask,
    input logic                  bypass
  );
    logic [DMEM_MAX_W-1:0] res;
    if (bypass) begin
      res = wdata;
    end else begin
      res = (wdata & ~mask) | (old & mask);
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_dp_ram.sv
// Dual-port synchronous RAM: port A read/write, port B read-only, both read-first.
module dmem_dp_ram #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 18,
  parameter int DEPTH     = 2**ADDR_W,
  parameter     INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              en_b,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  // Array write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (we_a) begin
      mem[addr_a] <= wdata_a;
    end
  end

  // Output registers sample the array before this edge's write lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_a <= {DATA_W{1'b0}};
      rdata_b <= {DATA_W{1'b0}};
    end else begin
      if (en_a) begin
        rdata_a <= mem[addr_a];
      end
      if (en_b) begin
        rdata_b <= mem[addr_b];
      end else begin
        rdata_b <= {DATA_W{1'b0}};
      end
    end
  end

endmodule

// File: rtl/data_memory_rmw.sv
// CPU data memory with protected-bit read-modify-write, independent readout port
// and a saturating counter of attempted protected-bit changes.
module data_memory_rmw
  import dmem_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 18,
  parameter int                DEPTH        = 2**ADDR_W,
  parameter logic [DATA_W-1:0] PROTECT_MASK = DATA_W'(DMEM_PROTECT_MASK_DEF),
  parameter int                CNT_W        = 16,
  parameter                    INIT_FILE    = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              prot_bypass,
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  input  logic [ADDR_W-1:0] addr_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              addr_err,
  output logic [CNT_W-1:0]  viol_cnt
);

  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  dmem_state_t       state;
  logic [ADDR_W-1:0] addr_cap;
  logic [DATA_W-1:0] wdata_cap;
  logic              byp_cap;
  logic              rd_oor;
  logic [DATA_W-1:0] rdata_hold;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] merged;
  logic              accept;
  logic              in_range_a;
  logic              in_range_b;
  logic              violation;

  assign accept     = req & ready;
  assign in_range_a = ({1'b0, addr} < DEPTH_L);
  assign in_range_b = ({1'b0, addr_b} < DEPTH_L);
  assign merged     = DATA_W'(dmem_merge(DMEM_MAX_W'(wdata_cap), DMEM_MAX_W'(ram_q),
                                         DMEM_MAX_W'(PROTECT_MASK), byp_cap));
  assign violation  = !byp_cap && (|((wdata_cap ^ ram_q) & PROTECT_MASK));

  // rdata follows the RAM only on the rvalid cycle so write-side reads never disturb it.
  assign rdata = rvalid ? (rd_oor ? {DATA_W{1'b0}} : ram_q) : rdata_hold;

  dmem_dp_ram #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .en_a   (accept & in_range_a),
    .we_a   (state == RMW),
    .addr_a ((state == RMW) ? addr_cap : addr),
    .wdata_a(merged),
    .rdata_a(ram_q),
    .en_b   (in_range_b),
    .addr_b (addr_b),
    .rdata_b(rdata_b)
  );

  // Request FSM, range flags and violation counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ready      <= 1'b0;
      rvalid     <= 1'b0;
      rd_oor     <= 1'b0;
      rdata_hold <= {DATA_W{1'b0}};
      addr_err   <= 1'b0;
      viol_cnt   <= {CNT_W{1'b0}};
      addr_cap   <= {ADDR_W{1'b0}};
      wdata_cap  <= {DATA_W{1'b0}};
      byp_cap    <= 1'b0;
    end else begin
      if (rvalid) begin
        rdata_hold <= rdata;
      end
      case (state)
        IDLE: begin
          ready    <= 1'b1;
          rvalid   <= 1'b0;
          addr_err <= 1'b0;
          if (accept) begin
            addr_err <= !in_range_a;
            if (!we) begin
              rvalid <= 1'b1;
              rd_oor <= !in_range_a;
            end else if (in_range_a) begin
              state     <= RMW;
              ready     <= 1'b0;
              addr_cap  <= addr;
              wdata_cap <= wdata;
              byp_cap   <= prot_bypass;
            end
          end
        end
        RMW: begin
          state    <= IDLE;
          ready    <= 1'b1;
          rvalid   <= 1'b0;
          addr_err <= 1'b0;
          if (violation && (viol_cnt != CNT_MAX)) begin
            viol_cnt <= viol_cnt + CNT_ONE;
          end
        end
        default: begin
          state    <= IDLE;
          ready    <= 1'b0;
          rvalid   <= 1'b0;
          addr_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_rmw.sv
// Directed plus randomized bench for data_memory_rmw against an array-based reference model.
module tb_data_memory_rmw;

  localparam int          AW    = 10;
  localparam int          DEPTH = 1000;
  localparam int          CW    = 2;
  localparam int          CMAX  = 3;
  localparam logic [31:0] MASK  = 32'h0000_003F;

  logic          clk;
  logic          rst;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic          prot_bypass;
  logic          ready;
  logic          rvalid;
  logic [31:0]   rdata;
  logic [AW-1:0] addr_b;
  logic [31:0]   rdata_b;
  logic          addr_err;
  logic [CW-1:0] viol_cnt;

  data_memory_rmw #(
    .DATA_W      (32),
    .ADDR_W      (AW),
    .DEPTH       (DEPTH),
    .PROTECT_MASK(MASK),
    .CNT_W       (CW),
    .INIT_FILE   ("")
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .prot_bypass(prot_bypass),
    .ready      (ready),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .addr_b     (addr_b),
    .rdata_b    (rdata_b),
    .addr_err   (addr_err),
    .viol_cnt   (viol_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks;
  int          n_fail;
  logic [31:0] mem_m [0:1023];
  bit          known [0:1023];
  int          viol_m;
  logic [31:0] last_rd;
  bit          last_rd_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input int a);
    logic [31:0] e;
    chk("r_ready", 32'(ready), 32'd1);
    req = 1'b1; we = 1'b0; addr = AW'(a);
    @(posedge clk); #1;
    req = 1'b0; addr = AW'($urandom);
    chk("r_rvalid", 32'(rvalid), 32'd1);
    chk("r_err", 32'(addr_err), (a >= DEPTH) ? 32'd1 : 32'd0);
    if (a >= DEPTH || known[a]) begin
      e = (a >= DEPTH) ? 32'd0 : mem_m[a];
      chk("r_data", rdata, e);
      last_rd = e;
      last_rd_known = 1'b1;
    end else begin
      last_rd_known = 1'b0;
    end
  endtask

  task automatic do_idle();
    @(posedge clk); #1;
    chk("i_rvalid", 32'(rvalid), 32'd0);
    chk("i_err", 32'(addr_err), 32'd0);
    if (last_rd_known) chk("i_rdata_hold", rdata, last_rd);
  endtask

  task automatic do_write(input int a, input logic [31:0] d, input logic byp, input bit settle);
    logic [31:0] old;
    logic [31:0] nw;
    bit          had;
    chk("w_ready", 32'(ready), 32'd1);
    req = 1'b1; we = 1'b1; addr = AW'(a); wdata = d; prot_bypass = byp;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0; wdata = $urandom; prot_bypass = 1'($urandom_range(0, 1));
    addr_b = AW'(a);
    chk("w_rvalid", 32'(rvalid), 32'd0);
    if (last_rd_known) chk("w_rdata_hold", rdata, last_rd);
    if (a >= DEPTH) begin
      chk("w_oor_err", 32'(addr_err), 32'd1);
      chk("w_oor_ready", 32'(ready), 32'd1);
      @(posedge clk); #1;
      chk("w_oor_portb", rdata_b, 32'd0);
      chk("w_oor_err_end", 32'(addr_err), 32'd0);
      chk("w_oor_viol", 32'(viol_cnt), 32'(viol_m));
    end else begin
      chk("w_err", 32'(addr_err), 32'd0);
      chk("w_busy", 32'(ready), 32'd0);
      had = known[a];
      old = mem_m[a];
      nw  = byp ? d : ((d & ~MASK) | (old & MASK));
      if (!byp && had && (((d ^ old) & MASK) != 32'd0) && viol_m < CMAX) viol_m++;
      @(posedge clk); #1;
      chk("w_ready_back", 32'(ready), 32'd1);
      if (had) chk("w_portb_old", rdata_b, old);
      chk("w_viol", 32'(viol_cnt), 32'(viol_m));
      if (had || byp) begin
        mem_m[a] = nw;
        known[a] = 1'b1;
      end
      if (settle && (had || byp)) begin
        @(posedge clk); #1;
        chk("w_portb_new", rdata_b, nw);
      end
    end
  endtask

  initial begin
    int a;
    int op;
    logic [31:0] d;
    logic [31:0] old3;
    n_checks = 0; n_fail = 0; viol_m = 0;
    last_rd = 32'd0; last_rd_known = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      known[i] = 1'b0;
      mem_m[i] = 32'd0;
    end
    clk = 1'b0; rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0;
    wdata = 32'd0; prot_bypass = 1'b0; addr_b = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rdata_b", rdata_b, 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);
    chk("rst_viol", 32'(viol_cnt), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", 32'(ready), 32'd1);

    // Fill a small working region with bypass writes
    for (int i = 0; i < 16; i++) do_write(i, $urandom, 1'b1, 1'b0);

    // Directed: read back, protected write, bypass write
    do_write(5, 32'hDEAD_BEEF, 1'b1, 1'b1);
    do_read(5);
    chk("tp_read5", rdata, 32'hDEAD_BEEF);
    do_idle();
    do_write(7, 32'h0000_002A, 1'b1, 1'b1);
    do_write(7, 32'hFFFF_FFC0, 1'b0, 1'b1);
    chk("tp_viol1", 32'(viol_cnt), 32'd1);
    do_read(7);
    chk("tp_mem7", rdata, 32'hFFFF_FFEA);
    do_write(7, 32'h1234_5678, 1'b1, 1'b1);
    chk("tp_viol_byp", 32'(viol_cnt), 32'd1);
    do_read(7);
    do_read(5);

    // Out of range
    do_write(1000, 32'hCAFE_F00D, 1'b0, 1'b0);
    do_read(1023);
    do_idle();
    do_read(999);

    // Read directly after a protected write
    do_write(4, 32'hA5A5_A5A5, 1'b0, 1'b0);
    do_read(4);

    // Randomized mix
    for (int n = 0; n < 150; n++) begin
      a  = ($urandom_range(0, 7) == 0) ? (1000 + $urandom_range(0, 23)) : $urandom_range(0, 15);
      op = $urandom_range(0, 4);
      d  = $urandom;
      if (op < 2)       do_read(a);
      else if (op == 4) do_idle();
      else              do_write(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an RMW
    do_write(3, 32'h1111_1111, 1'b1, 1'b1);
    old3 = mem_m[3];
    chk("mr_ready", 32'(ready), 32'd1);
    req = 1'b1; we = 1'b1; addr = AW'(3); wdata = 32'hAAAA_AA80; prot_bypass = 1'b0;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    chk("mr_busy", 32'(ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mr_ready0", 32'(ready), 32'd0);
    chk("mr_rvalid0", 32'(rvalid), 32'd0);
    chk("mr_rdata0", rdata, 32'd0);
    chk("mr_rdata_b0", rdata_b, 32'd0);
    chk("mr_err0", 32'(addr_err), 32'd0);
    chk("mr_viol0", 32'(viol_cnt), 32'd0);
    viol_m = 0;
    last_rd = 32'd0; last_rd_known = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mr_ready_rel", 32'(ready), 32'd1);
    do_read(3);
    chk("mr_mem3", rdata, old3);

    // Counter saturation from zero: 1,2,3,3,3
    for (int k = 0; k < 5; k++) begin
      d = {$urandom_range(0, 65535), 10'd0, ~mem_m[9][5:0]};
      do_write(9, d, 1'b0, 1'b0);
      chk("sat_seq", 32'(viol_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    do_read(9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
